// File: rtl/t01_ai_cand_seq_pkg.sv
// t01_ai_pkg: shared types and constants for the Tetris AI candidate sequencer.
// Holds the piece family and FSM state enums, the block-type count and the
// per-family (first type, rotation count) table.
package t01_ai_pkg;

  localparam int unsigned NUM_TYPES = 19;
  localparam int unsigned TYPE_W    = 5;
  localparam int unsigned X_W       = 4;
  localparam int unsigned PIECE_W   = 3;
  localparam int unsigned WIDTH_W   = 3;
  localparam int unsigned ROT_W     = 3;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_I   = 3'd0,
    PIECE_O   = 3'd1,
    PIECE_S   = 3'd2,
    PIECE_Z   = 3'd3,
    PIECE_L   = 3'd4,
    PIECE_J   = 3'd5,
    PIECE_T   = 3'd6,
    PIECE_INV = 3'd7
  } piece_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  localparam logic [TYPE_W-1:0] FIRST_I = 5'd0;
  localparam logic [TYPE_W-1:0] FIRST_O = 5'd2;
  localparam logic [TYPE_W-1:0] FIRST_S = 5'd3;
  localparam logic [TYPE_W-1:0] FIRST_Z = 5'd5;
  localparam logic [TYPE_W-1:0] FIRST_L = 5'd7;
  localparam logic [TYPE_W-1:0] FIRST_J = 5'd11;
  localparam logic [TYPE_W-1:0] FIRST_T = 5'd15;

  localparam logic [ROT_W-1:0] ROT_I = 3'd2;
  localparam logic [ROT_W-1:0] ROT_O = 3'd1;
  localparam logic [ROT_W-1:0] ROT_S = 3'd2;
  localparam logic [ROT_W-1:0] ROT_Z = 3'd2;
  localparam logic [ROT_W-1:0] ROT_L = 3'd4;
  localparam logic [ROT_W-1:0] ROT_J = 3'd4;
  localparam logic [ROT_W-1:0] ROT_T = 3'd4;

endpackage

// File: rtl/t01_ai_cand_seq_if.sv
// t01_ai_cand_seq_if: candidate handshake between the sequencer and the MMU scorer.
//   mmu_start    : one-cycle pulse, score the current candidate
//   mmu_done     : one-cycle pulse, scoring finished
//   blockX_o     : candidate left-edge column
//   block_type_o : candidate block type 0..18
// master = sequencer side, slave = MMU / selector side.
interface t01_ai_cand_seq_if;
  import t01_ai_pkg::*;

  logic              mmu_start;
  logic              mmu_done;
  logic [X_W-1:0]    blockX_o;
  logic [TYPE_W-1:0] block_type_o;

  modport master (
    output mmu_start,
    output blockX_o,
    output block_type_o,
    input  mmu_done
  );

  modport slave (
    input  mmu_start,
    input  blockX_o,
    input  block_type_o,
    output mmu_done
  );

endinterface

// File: rtl/t01_ai_piece_lut.sv
// t01_ai_piece_lut: combinational piece geometry lookup.
//   block_type   in  : block type whose width is wanted
//   piece        in  : piece family
//   width_c      out : width in columns of block_type (0 for out-of-range types)
//   first_type_c out : first block type of the family
//   rot_cnt_c    out : number of rotations (block types) of the family
module t01_ai_piece_lut
  import t01_ai_pkg::*;
(
  input  logic [TYPE_W-1:0]  block_type,
  input  piece_e             piece,
  output logic [WIDTH_W-1:0] width_c,
  output logic [TYPE_W-1:0]  first_type_c,
  output logic [ROT_W-1:0]   rot_cnt_c
);

  // Width per block type: I 4/1, O 2, then S/Z/L/J/T alternate 3,2 from their first type.
  always_comb begin
    width_c = WIDTH_W'(0);
    if (block_type < TYPE_W'(NUM_TYPES)) begin
      case (block_type)
        5'd0:    width_c = WIDTH_W'(4);
        5'd1:    width_c = WIDTH_W'(1);
        5'd2:    width_c = WIDTH_W'(2);
        5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15, 5'd17:
                 width_c = WIDTH_W'(3);
        default: width_c = WIDTH_W'(2);
      endcase
    end
  end

  // Family to (first type, rotation count); the invalid family has no rotations.
  always_comb begin
    first_type_c = TYPE_W'(0);
    rot_cnt_c    = ROT_W'(0);
    case (piece)
      PIECE_I: begin first_type_c = FIRST_I; rot_cnt_c = ROT_I; end
      PIECE_O: begin first_type_c = FIRST_O; rot_cnt_c = ROT_O; end
      PIECE_S: begin first_type_c = FIRST_S; rot_cnt_c = ROT_S; end
      PIECE_Z: begin first_type_c = FIRST_Z; rot_cnt_c = ROT_Z; end
      PIECE_L: begin first_type_c = FIRST_L; rot_cnt_c = ROT_L; end
      PIECE_J: begin first_type_c = FIRST_J; rot_cnt_c = ROT_J; end
      PIECE_T: begin first_type_c = FIRST_T; rot_cnt_c = ROT_T; end
      default: begin first_type_c = TYPE_W'(0); rot_cnt_c = ROT_W'(0); end
    endcase
  end

endmodule

// File: rtl/t01_ai_cand_seq.sv
// t01_ai_cand_seq: issues every legal (block_type, blockX) placement of a piece
// to the MMU scorer, one at a time, holding each until mmu_done.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin evaluation of piece_i (sampled only when idle)
//   piece_i     : piece family 0..6, 7 = invalid (no candidates)
//   mmu         : candidate handshake (mmu_start, mmu_done, blockX_o, block_type_o)
//   sel_clear   : pulse on start acceptance, clears the best-result selector
//   busy        : high while a run is in progress
//   done        : pulse once all candidates of a run are issued
//   cand_count  : candidates completed in the current or last run
//   timeout_err : sticky watchdog flag (only with T01_AI_SEQ_TIMEOUT_EN)
// Optional macro T01_AI_SEQ_TIMEOUT_EN: skip a candidate whose mmu_done does not
// arrive within TIMEOUT cycles and flag timeout_err.
module t01_ai_cand_seq
  import t01_ai_pkg::*;
#(
  parameter int unsigned NUM_COLS = 10,
  parameter int unsigned CNT_W    = 6
`ifdef T01_AI_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 255
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PIECE_W-1:0]   piece_i,
  t01_ai_cand_seq_if.master    mmu,
  output logic                 sel_clear,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     cand_count
`ifdef T01_AI_SEQ_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  state_e             state_q, state_nxt;
  piece_e             piece_q, piece_nxt;
  logic [TYPE_W-1:0]  type_q, type_nxt;
  logic [X_W-1:0]     x_q, x_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               mmu_start_q, mmu_start_nxt;
  logic               sel_clear_q, sel_clear_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;

  piece_e             lut_piece_c;
  logic [WIDTH_W-1:0] width_c;
  logic [TYPE_W-1:0]  first_type_c;
  logic [ROT_W-1:0]   rot_cnt_c;
  logic [TYPE_W-1:0]  last_type_c;
  logic [X_W-1:0]     xmax_c;

`ifdef T01_AI_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wdog_q, wdog_nxt;
  logic            terr_q, terr_nxt;
`endif

  // While idle the table must describe the incoming piece so its first type can be loaded.
  assign lut_piece_c = (state_q == ST_IDLE) ? piece_e'(piece_i) : piece_q;

  t01_ai_piece_lut u_lut (
    .block_type   (type_q),
    .piece        (lut_piece_c),
    .width_c      (width_c),
    .first_type_c (first_type_c),
    .rot_cnt_c    (rot_cnt_c)
  );

  assign last_type_c = first_type_c + TYPE_W'(rot_cnt_c) - TYPE_W'(1);
  assign xmax_c      = X_W'(NUM_COLS) - X_W'(width_c);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state_q;
    piece_nxt     = piece_q;
    type_nxt      = type_q;
    x_nxt         = x_q;
    cnt_nxt       = cnt_q;
    mmu_start_nxt = 1'b0;
    sel_clear_nxt = 1'b0;
`ifdef T01_AI_SEQ_TIMEOUT_EN
    wdog_nxt      = '0;
    terr_nxt      = terr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt = '0;
          if (piece_e'(piece_i) == PIECE_INV) begin
            state_nxt = ST_FIN;
          end else begin
            piece_nxt     = piece_e'(piece_i);
            type_nxt      = first_type_c;
            x_nxt         = '0;
            sel_clear_nxt = 1'b1;
            mmu_start_nxt = 1'b1;
            state_nxt     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mmu.mmu_done) begin
          cnt_nxt   = cnt_q + CNT_W'(1);
          state_nxt = ST_ADVANCE;
        end
`ifdef T01_AI_SEQ_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          terr_nxt  = 1'b1;
          state_nxt = ST_ADVANCE;
        end else begin
          wdog_nxt = wdog_q + WD_W'(1);
        end
`endif
      end
      ST_ADVANCE: begin
        if (x_q < xmax_c) begin
          x_nxt         = x_q + X_W'(1);
          mmu_start_nxt = 1'b1;
          state_nxt     = ST_ISSUE;
        end else if (type_q < last_type_c) begin
          type_nxt      = type_q + TYPE_W'(1);
          x_nxt         = '0;
          mmu_start_nxt = 1'b1;
          state_nxt     = ST_ISSUE;
        end else begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt != ST_IDLE);
  // done is registered off FIN, so it lands on the cycle after FIN.
  assign done_nxt = (state_q == ST_FIN);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      piece_q     <= PIECE_I;
      type_q      <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      mmu_start_q <= 1'b0;
      sel_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef T01_AI_SEQ_TIMEOUT_EN
      wdog_q      <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_nxt;
      piece_q     <= piece_nxt;
      type_q      <= type_nxt;
      x_q         <= x_nxt;
      cnt_q       <= cnt_nxt;
      mmu_start_q <= mmu_start_nxt;
      sel_clear_q <= sel_clear_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
`ifdef T01_AI_SEQ_TIMEOUT_EN
      wdog_q      <= wdog_nxt;
      terr_q      <= terr_nxt;
`endif
    end
  end

  assign mmu.mmu_start    = mmu_start_q;
  assign mmu.blockX_o     = x_q;
  assign mmu.block_type_o = type_q;
  assign sel_clear        = sel_clear_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cand_count       = cnt_q;
`ifdef T01_AI_SEQ_TIMEOUT_EN
  assign timeout_err      = terr_q;
`endif

endmodule

// File: tb/tb_t01_ai_cand_seq.sv
// tb_t01_ai_cand_seq: self-checking bench for t01_ai_cand_seq.
// Table of per-piece runs, hand sequences for invalid piece / mid-run reset /
// ignored start and spurious mmu_done, and randomized runs with a random MMU
// latency, all checked against a candidate-list model built from the piece rules.
module tb_t01_ai_cand_seq;
  import t01_ai_pkg::*;

  localparam int unsigned NUM_COLS = 10;
  localparam int unsigned CNT_W    = 6;
  localparam int MAX_CYC = 4000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       piece_i;
  logic             sel_clear;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cand_count;
`ifdef T01_AI_SEQ_TIMEOUT_EN
  logic             timeout_err;
`endif

  t01_ai_cand_seq_if mmu_if ();

  t01_ai_cand_seq #(
    .NUM_COLS (NUM_COLS),
    .CNT_W    (CNT_W)
`ifdef T01_AI_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT  (20)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .piece_i    (piece_i),
    .mmu        (mmu_if),
    .sel_clear  (sel_clear),
    .busy       (busy),
    .done       (done),
    .cand_count (cand_count)
`ifdef T01_AI_SEQ_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int btype;
    int x;
  } cand_t;

  typedef struct {
    int piece;
    int lat;
    int exp_cnt;
    int exp_type;
    int exp_x;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  cand_t exp_q[$];
  cand_t got_q[$];
  int    r_sel, r_sel_bad, r_gap_bad, r_hold_bad, r_first, r_done, r_ok;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every legal placement: for each rotation r of the family, x runs 0..NUM_COLS-width.
  function automatic void model(input int p);
    int first[7];
    int rots[7];
    first = '{0, 2, 3, 5, 7, 11, 15};
    rots  = '{2, 1, 2, 2, 4, 4, 4};
    exp_q.delete();
    if (p < 0 || p > 6) return;
    for (int r = 0; r < rots[p]; r++) begin
      int w;
      if (p == 0)      w = (r == 0) ? 4 : 1;
      else if (p == 1) w = 2;
      else             w = (r % 2 == 0) ? 3 : 2;
      for (int x = 0; x <= int'(NUM_COLS) - w; x++) begin
        cand_t c;
        c.btype = first[p] + r;
        c.x     = x;
        exp_q.push_back(c);
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mmu_if.mmu_done = 1'b0; piece_i = 3'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_mmu_start"}, int'(mmu_if.mmu_start), 0);
    chk({name, "_blockX"}, int'(mmu_if.blockX_o), 0);
    chk({name, "_type"}, int'(mmu_if.block_type_o), 0);
    chk({name, "_sel_clear"}, int'(sel_clear), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_cand_count"}, int'(cand_count), 0);
`ifdef T01_AI_SEQ_TIMEOUT_EN
    chk({name, "_timeout_err"}, int'(timeout_err), 0);
`endif
  endtask

  // Start piece p and act as the MMU. restart_at: cycle of a stray start pulse;
  // withhold: candidate index never answered; abort_at: candidate index whose
  // WAIT gets a reset. Indices < 0 disable the feature.
  task automatic run_piece(input int p, input int lat_min, input int lat_max,
                           input int restart_at, input int withhold, input int abort_at);
    int cd;
    int last_done;
    bit gap_armed;
    bit abort_now;
    got_q.delete();
    r_sel = 0; r_sel_bad = 0; r_gap_bad = 0; r_hold_bad = 0; r_first = -1; r_done = 0; r_ok = 0;
    cd = -1; last_done = 0; gap_armed = 1'b0; abort_now = 1'b0;
    @(negedge clk);
    start = 1'b1; piece_i = 3'(p);
    @(negedge clk);
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      start = 1'b0;
      mmu_if.mmu_done = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1; piece_i = 3'd1;
      end
      if (abort_now) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrun_rst");
        r_ok = 1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (done) r_done++;
        end
        chk("midrun_rst_no_done", r_done, 0);
        break;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mmu_if.mmu_done = 1'b1;
          last_done = cyc;
          gap_armed = 1'b1;
          cd = -1;
          if (got_q.size() > 0 &&
              (got_q[$].btype != int'(mmu_if.block_type_o) || got_q[$].x != int'(mmu_if.blockX_o)))
            r_hold_bad++;
        end
      end
      if (sel_clear) begin
        r_sel++;
        if (cyc != 0) r_sel_bad++;
      end
      if (mmu_if.mmu_start) begin
        cand_t c;
        if (r_first < 0) r_first = cyc;
        else if (gap_armed && (cyc - last_done) != 2) r_gap_bad++;
        gap_armed = 1'b0;
        c.btype = int'(mmu_if.block_type_o);
        c.x     = int'(mmu_if.blockX_o);
        got_q.push_back(c);
        if (got_q.size() - 1 == abort_at) abort_now = 1'b1;
        if (got_q.size() - 1 == withhold) cd = -1;
        else cd = int'($urandom_range(lat_max, lat_min));
      end
      if (done) begin
        r_done++;
        r_ok = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          mmu_if.mmu_done = 1'b0;
          if (done) r_done++;
        end
        break;
      end
      @(negedge clk);
    end
    if (r_ok == 0) chk("run_cycle_budget", 0, 1);
  endtask

  task automatic check_run(input string name, input int exp_cnt, input int exp_type, input int exp_x);
    int bad;
    int first_bad;
    chk({name, "_sel_clear_pulses"}, r_sel, 1);
    chk({name, "_sel_clear_late"}, r_sel_bad, 0);
    chk({name, "_first_start_cycle"}, r_first, 0);
    chk({name, "_done_to_start_gap"}, r_gap_bad, 0);
    chk({name, "_hold_in_wait"}, r_hold_bad, 0);
    chk({name, "_done_pulses"}, r_done, 1);
    chk({name, "_num_mmu_start"}, got_q.size(), exp_q.size());
    bad = 0; first_bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].btype != exp_q[i].btype || got_q[i].x != exp_q[i].x) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (first_bad >= 0)
      $display("  %s first candidate difference at index %0d: got type %0d x %0d, expected type %0d x %0d",
               name, first_bad, got_q[first_bad].btype, got_q[first_bad].x,
               exp_q[first_bad].btype, exp_q[first_bad].x);
    chk({name, "_candidate_list"}, bad, 0);
    chk({name, "_cand_count"}, int'(cand_count), exp_cnt);
    chk({name, "_last_type"}, int'(mmu_if.block_type_o), exp_type);
    chk({name, "_last_x"}, int'(mmu_if.blockX_o), exp_x);
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    #5000000;
    $display("FAIL global_time_limit: got no end of test, expected $finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; piece_i = 3'd0; mmu_if.mmu_done = 1'b0;

    vecs[0] = '{1, 3, 9, 2, 8};
    vecs[1] = '{0, 3, 17, 1, 9};
    vecs[2] = '{2, 2, 17, 4, 8};
    vecs[3] = '{3, 4, 17, 6, 8};
    vecs[4] = '{4, 2, 34, 10, 8};
    vecs[5] = '{5, 3, 34, 14, 8};
    vecs[6] = '{6, 2, 34, 18, 8};

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Invalid piece straight out of reset: no candidates, done 2 cycles after start
    @(negedge clk);
    start = 1'b1; piece_i = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("inv_mmu_start_c1", int'(mmu_if.mmu_start), 0);
    chk("inv_done_c1", int'(done), 0);
    chk("inv_sel_clear_c1", int'(sel_clear), 0);
    @(negedge clk);
    chk("inv_done_c2", int'(done), 1);
    chk("inv_mmu_start_c2", int'(mmu_if.mmu_start), 0);
    chk("inv_cand_count", int'(cand_count), 0);
    @(negedge clk);
    chk("inv_done_c3", int'(done), 0);

    // Per-piece table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_piece(vecs[i].piece, vecs[i].lat, vecs[i].lat, -1, -1, -1);
      model(vecs[i].piece);
      check_run($sformatf("tbl_piece%0d", vecs[i].piece), vecs[i].exp_cnt, vecs[i].exp_type, vecs[i].exp_x);
    end

    // Spurious mmu_done while idle, then T with an ignored start mid-run
    @(negedge clk);
    mmu_if.mmu_done = 1'b1;
    @(negedge clk);
    mmu_if.mmu_done = 1'b0;
    chk("idle_done_mmu_start", int'(mmu_if.mmu_start), 0);
    chk("idle_done_busy", int'(busy), 0);
    run_piece(6, 3, 3, 10, -1, -1);
    model(6);
    check_run("T_restart", 34, 18, 8);

    // Reset in WAIT of the 5th L candidate, then a fresh full run
    run_piece(4, 3, 3, -1, -1, 4);
    chk("midrun_rst_issued", got_q.size(), 5);
    run_piece(4, 3, 3, -1, -1, -1);
    model(4);
    check_run("L_after_rst", 34, 10, 8);

    // Randomized runs with random MMU latency
    for (int i = 0; i < 6; i++) begin
      int p;
      p = int'($urandom_range(6, 0));
      run_piece(p, 2, 6, -1, -1, -1);
      model(p);
      check_run($sformatf("rnd%0d_piece%0d", i, p), exp_q.size(), exp_q[$].btype, exp_q[$].x);
    end

`ifdef T01_AI_SEQ_TIMEOUT_EN
    // Watchdog: second O candidate never answered
    do_reset();
    run_piece(1, 3, 3, -1, 1, -1);
    model(1);
    chk("wd_num_mmu_start", got_q.size(), 9);
    chk("wd_cand_count", int'(cand_count), 8);
    chk("wd_timeout_err", int'(timeout_err), 1);
    chk("wd_done_pulses", r_done, 1);
    do_reset();
    chk("wd_timeout_err_cleared", int'(timeout_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
